// File: rtl/video_roi_cropper_if.sv
// Avalon-ST video beat bundle: one pixel per beat with packet framing and backpressure.
// The sink side does not consume 'empty'; every beat carries exactly one pixel.
interface video_roi_cropper_if #(
  parameter int DATA_W = 24
);
  logic [DATA_W-1:0] data;
  logic              startofpacket;
  logic              endofpacket;
  logic [1:0]        empty;
  logic              valid;
  logic              ready;

  modport master (output data, startofpacket, endofpacket, empty, valid, input ready);
  modport slave  (input data, startofpacket, endofpacket, valid, output ready);
endinterface

// File: rtl/video_roi_cropper.sv
// Crops a streamed RGB frame to a runtime rectangle and re-frames it as one output packet.
// Two-entry skid output (main + skid) gives a registered in_ready and 1 pixel/clk throughput.
module video_roi_cropper #(
  parameter int IN_WIDTH  = 320,
  parameter int IN_HEIGHT = 240,
  parameter int DATA_W    = 24,
  parameter int CW        = 9
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic [CW-1:0]       roi_x,
  input  logic [CW-1:0]       roi_y,
  input  logic [CW-1:0]       roi_w,
  input  logic [CW-1:0]       roi_h,
  video_roi_cropper_if.slave  in_st,
  video_roi_cropper_if.master out_st,
  output logic                frame_done,
  output logic                frame_error,
  output logic                roi_invalid
);
  localparam int              NPIX     = IN_WIDTH * IN_HEIGHT;
  localparam int              CNT_W    = $clog2(NPIX + 2);
  localparam logic [CW:0]     W_LIM    = (CW+1)'(IN_WIDTH);
  localparam logic [CW:0]     H_LIM    = (CW+1)'(IN_HEIGHT);
  localparam logic [CW-1:0]   X_LAST   = CW'(IN_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NPIX);

  typedef enum logic [1:0] {IDLE, ACTIVE, CLOSE} state_t;

  function automatic logic [CW-1:0] sat_inc_y(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t              state_q, state_n;
  logic [CW-1:0]       x_q, y_q, rx_q, ry_q, rw_q, rh_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                pkt_open_q, in_ready_q, hold_eop_q;
  logic                frame_done_q, frame_error_q, roi_invalid_q;
  logic [DATA_W-1:0]   hold_data_q;
  logic [DATA_W-1:0]   data_p1, skid_data_p1;
  logic                sop_p1, eop_p1, vld_p1;
  logic                skid_sop_p1, skid_eop_p1, skid_vld_p1;

  logic                accept, pop, roi_bad, latch, proc, start, go_close, err_restart;
  logic [CW:0]         sx, sy, ex_end, ey_end;
  logic [CW-1:0]       nrx, nry, nrw, nrh, erx, ery, erw, erh, ex, ey;
  logic [CNT_W-1:0]    ecnt, cnt_inc;
  logic [DATA_W-1:0]   b_data, push_data;
  logic                b_eop, keep, f_sop, f_eop, open_eff, push, push_sop, push_eop;
  logic                main_load, main_from_skid, skid_load, vld_n, skid_vld_n;

  assign accept  = in_st.valid & in_ready_q;
  assign pop     = vld_p1 & out_st.ready;

  // Illegal rectangles fall back to the whole frame.
  assign sx      = {1'b0, roi_x} + {1'b0, roi_w};
  assign sy      = {1'b0, roi_y} + {1'b0, roi_h};
  assign roi_bad = (roi_w == '0) | (roi_h == '0) | (sx > W_LIM) | (sy > H_LIM);
  assign nrx     = roi_bad ? '0 : roi_x;
  assign nry     = roi_bad ? '0 : roi_y;
  assign nrw     = roi_bad ? CW'(IN_WIDTH)  : roi_w;
  assign nrh     = roi_bad ? CW'(IN_HEIGHT) : roi_h;

  always_comb begin
    state_n     = state_q;
    proc        = 1'b0;
    start       = 1'b0;
    latch       = 1'b0;
    go_close    = 1'b0;
    err_restart = 1'b0;
    b_data      = in_st.data;
    b_eop       = in_st.endofpacket;
    case (state_q)
      IDLE: begin
        if (accept && in_st.startofpacket) begin
          proc  = 1'b1;
          start = 1'b1;
          latch = 1'b1;
        end
      end
      ACTIVE: begin
        if (accept) begin
          if (in_st.startofpacket) begin
            latch       = 1'b1;
            err_restart = 1'b1;
            if (pkt_open_q) begin
              go_close = 1'b1;
            end else begin
              proc  = 1'b1;
              start = 1'b1;
            end
          end else begin
            proc = 1'b1;
          end
        end
      end
      CLOSE: begin
        // Held SOP beat is replayed once the filler has room behind it.
        if (!skid_vld_p1) begin
          proc   = 1'b1;
          start  = 1'b1;
          b_data = hold_data_q;
          b_eop  = hold_eop_q;
        end
      end
      default: state_n = IDLE;
    endcase
    if (go_close)  state_n = CLOSE;
    else if (proc) state_n = b_eop ? IDLE : ACTIVE;
  end

  // Stage p0: classify the beat against the rectangle in force for this frame.
  assign erx       = latch ? nrx : rx_q;
  assign ery       = latch ? nry : ry_q;
  assign erw       = latch ? nrw : rw_q;
  assign erh       = latch ? nrh : rh_q;
  assign ex        = start ? '0 : x_q;
  assign ey        = start ? '0 : y_q;
  assign ecnt      = start ? '0 : cnt_q;
  assign cnt_inc   = sat_inc_cnt(ecnt);
  assign ex_end    = {1'b0, erx} + {1'b0, erw};
  assign ey_end    = {1'b0, ery} + {1'b0, erh};
  assign keep      = proc & (ecnt < CNT_FULL) & (ex >= erx) & ({1'b0, ex} < ex_end)
                   & (ey >= ery) & ({1'b0, ey} < ey_end);
  assign f_sop     = keep & (ex == erx) & (ey == ery);
  assign f_eop     = keep & ({1'b0, ex} == ex_end - (CW+1)'(1))
                   & ({1'b0, ey} == ey_end - (CW+1)'(1));
  assign open_eff  = ~start & pkt_open_q;
  assign push      = go_close | keep | (proc & b_eop & open_eff);
  assign push_sop  = f_sop;
  assign push_eop  = go_close | f_eop | (proc & b_eop & (open_eff | f_sop));
  assign push_data = go_close ? '0 : b_data;

  always_comb begin
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    vld_n          = vld_p1;
    skid_vld_n     = skid_vld_p1;
    if (skid_vld_p1) begin
      if (pop) begin
        main_from_skid = 1'b1;
        skid_vld_n     = 1'b0;
      end
    end else if (push) begin
      if (!vld_p1 || pop) begin
        main_load = 1'b1;
        vld_n     = 1'b1;
      end else begin
        skid_load  = 1'b1;
        skid_vld_n = 1'b1;
      end
    end else if (pop) begin
      vld_n = 1'b0;
    end
  end

  // Stage p1: output main register, frame tracking and status.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q       <= IDLE;
      x_q           <= '0;
      y_q           <= '0;
      cnt_q         <= '0;
      rx_q          <= '0;
      ry_q          <= '0;
      rw_q          <= '0;
      rh_q          <= '0;
      roi_invalid_q <= 1'b0;
      pkt_open_q    <= 1'b0;
      in_ready_q    <= 1'b0;
      hold_eop_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_error_q <= 1'b0;
      vld_p1        <= 1'b0;
      skid_vld_p1   <= 1'b0;
      data_p1       <= '0;
      sop_p1        <= 1'b0;
      eop_p1        <= 1'b0;
    end else begin
      state_q       <= state_n;
      in_ready_q    <= ~skid_vld_n & (state_n != CLOSE);
      vld_p1        <= vld_n;
      skid_vld_p1   <= skid_vld_n;
      frame_done_q  <= proc & b_eop;
      frame_error_q <= err_restart | (proc & b_eop & (cnt_inc != CNT_FULL));
      if (proc) begin
        x_q   <= (ex == X_LAST) ? '0 : ex + CW'(1);
        y_q   <= (ex == X_LAST) ? sat_inc_y(ey) : ey;
        cnt_q <= cnt_inc;
      end
      if (latch) begin
        rx_q          <= nrx;
        ry_q          <= nry;
        rw_q          <= nrw;
        rh_q          <= nrh;
        roi_invalid_q <= roi_bad;
      end
      if (go_close) begin
        pkt_open_q <= 1'b0;
        hold_eop_q <= in_st.endofpacket;
      end else if (push) begin
        pkt_open_q <= (open_eff | push_sop) & ~push_eop;
      end
      if (main_load) begin
        data_p1 <= push_data;
        sop_p1  <= push_sop;
        eop_p1  <= push_eop;
      end else if (main_from_skid) begin
        data_p1 <= skid_data_p1;
        sop_p1  <= skid_sop_p1;
        eop_p1  <= skid_eop_p1;
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (skid_load) begin
      skid_data_p1 <= push_data;
      skid_sop_p1  <= push_sop;
      skid_eop_p1  <= push_eop;
    end
    if (go_close) hold_data_q <= in_st.data;
  end

  assign in_st.ready          = in_ready_q;
  assign out_st.data          = data_p1;
  assign out_st.startofpacket = sop_p1;
  assign out_st.endofpacket   = eop_p1;
  assign out_st.empty         = '0;
  assign out_st.valid         = vld_p1;
  assign frame_done           = frame_done_q;
  assign frame_error          = frame_error_q;
  assign roi_invalid          = roi_invalid_q;
endmodule

// File: tb/tb_video_roi_cropper.sv
// Directed bench for video_roi_cropper on a reduced 32x24 frame (ROI cases scaled from 320x240).
// Pixel data encodes {frame id, in-frame index} so every output beat identifies its source.
module tb_video_roi_cropper;
  localparam int W  = 32;
  localparam int H  = 24;
  localparam int DW = 24;
  localparam int CW = 6;
  localparam int NPIX = W * H;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] roi_x = '0, roi_y = '0, roi_w = '0, roi_h = '0;
  logic          frame_done, frame_error, roi_invalid;

  video_roi_cropper_if #(.DATA_W(DW)) in_if ();
  video_roi_cropper_if #(.DATA_W(DW)) out_if ();

  video_roi_cropper #(.IN_WIDTH(W), .IN_HEIGHT(H), .DATA_W(DW), .CW(CW)) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .roi_x         (roi_x),
    .roi_y         (roi_y),
    .roi_w         (roi_w),
    .roi_h         (roi_h),
    .in_st         (in_if),
    .out_st        (out_if),
    .frame_done    (frame_done),
    .frame_error   (frame_error),
    .roi_invalid   (roi_invalid)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  logic [DW-1:0] cap_data[$];
  logic [1:0]    cap_flags[$];
  int done_cnt, err_cnt, both_cnt, inrdy_low, stab_viol, skid_viol;
  logic stall_mode = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Output sink: 1-on/2-off ready pattern when stalling.
  initial begin
    int ph;
    ph = 0;
    out_if.ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_if.ready = stall_mode ? (ph == 0) : 1'b1;
      ph = (ph == 2) ? 0 : ph + 1;
    end
  end

  // Monitor sampled on the falling edge.
  initial begin
    logic prev_stall;
    logic [DW+2:0] prev_beat;
    prev_stall = 1'b0;
    prev_beat = '0;
    forever begin
      @(negedge clk);
      if (out_if.valid && out_if.ready) begin
        cap_data.push_back(out_if.data);
        cap_flags.push_back({out_if.startofpacket, out_if.endofpacket});
      end
      if (frame_done) done_cnt++;
      if (frame_error) err_cnt++;
      if (frame_done && frame_error) both_cnt++;
      if (rst_n && !in_if.ready) inrdy_low++;
      if (stall_mode && rst_n && !in_if.ready && !out_if.valid) skid_viol++;
      if (rst_n && prev_stall &&
          ({out_if.valid, out_if.startofpacket, out_if.endofpacket, out_if.data} != prev_beat))
        stab_viol++;
      prev_stall = rst_n && out_if.valid && !out_if.ready;
      prev_beat  = {out_if.valid, out_if.startofpacket, out_if.endofpacket, out_if.data};
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic clear_obs();
    cap_data.delete();
    cap_flags.delete();
    done_cnt = 0; err_cnt = 0; both_cnt = 0;
    inrdy_low = 0; stab_viol = 0; skid_viol = 0;
  endtask

  task automatic drain();
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input int fid, input int idx, input logic sop, input logic eop);
    int t;
    logic [7:0]  f8;
    logic [15:0] i16;
    f8  = fid[7:0];
    i16 = idx[15:0];
    in_if.valid = 1'b1;
    in_if.data = {f8, i16};
    in_if.startofpacket = sop;
    in_if.endofpacket = eop;
    t = 0;
    @(negedge clk);
    while (!in_if.ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("in_ready_timeout", 32'(in_if.ready), 32'd1);
    @(posedge clk);
    #1;
    in_if.valid = 1'b0;
    in_if.startofpacket = 1'b0;
    in_if.endofpacket = 1'b0;
  endtask

  task automatic send_frame(input int fid, input int first, input int last,
                            input logic sop, input logic eop, input logic scramble);
    for (int i = first; i <= last; i++) begin
      send_beat(fid, i, sop && (i == first), eop && (i == last));
      if (scramble && i == first) begin
        roi_x = '0;
        roi_w = 6'd1;
      end
    end
  endtask

  task automatic check_beat(input string tag, input int pos, input int fid, input int idx,
                            input logic [1:0] flg);
    logic [7:0]    f8;
    logic [15:0]   i16;
    logic [DW-1:0] exp_d;
    f8 = fid[7:0];
    i16 = idx[15:0];
    exp_d = {f8, i16};
    if (pos < cap_data.size()) begin
      check($sformatf("%s_data%0d", tag, pos), 32'(cap_data[pos]), 32'(exp_d));
      check($sformatf("%s_flags%0d", tag, pos), 32'(cap_flags[pos]), 32'(flg));
    end
  endtask

  task automatic check_crop(input string tag, input int pos, input int fid,
                            input int rx, input int ry, input int rw, input int rh);
    for (int k = 0; k < rw * rh; k++)
      check_beat(tag, pos + k, fid, (ry + k / rw) * W + rx + k % rw,
                 {k == 0, k == rw * rh - 1});
  endtask

  task automatic set_roi(input int x, input int y, input int w, input int h);
    roi_x = x[CW-1:0];
    roi_y = y[CW-1:0];
    roi_w = w[CW-1:0];
    roi_h = h[CW-1:0];
  endtask

  initial begin
    in_if.valid = 1'b0;
    in_if.data = '0;
    in_if.startofpacket = 1'b0;
    in_if.endofpacket = 1'b0;
    in_if.empty = '0;
    clear_obs();
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", 32'({out_if.valid, out_if.startofpacket, out_if.endofpacket, out_if.data}), 32'd0);
    check("rst_status", 32'({frame_done, frame_error, roi_invalid, in_if.ready}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_if.ready), 32'd1);
    check("out_empty", 32'(out_if.empty), 32'd0);

    // ROI (10,5,8,4): 32 beats, SOP at 5*32+10=170, EOP at 8*32+17=273; ROI changed mid-frame.
    set_roi(10, 5, 8, 4);
    clear_obs();
    send_frame(1, 0, NPIX - 1, 1'b1, 1'b1, 1'b1);
    drain();
    check("t1_len", 32'(cap_data.size()), 32'd32);
    check_crop("t1", 0, 1, 10, 5, 8, 4);
    if (cap_data.size() > 0) begin
      check("t1_sop_idx", 32'(cap_data[0][15:0]), 32'd170);
      check("t1_eop_idx", 32'(cap_data[cap_data.size() - 1][15:0]), 32'd273);
    end
    check("t1_done", 32'(done_cnt), 32'd1);
    check("t1_err", 32'(err_cnt), 32'd0);
    check("t1_roi_inv", 32'(roi_invalid), 32'd0);

    // Same frame under 1-on/2-off backpressure.
    set_roi(10, 5, 8, 4);
    clear_obs();
    stall_mode = 1'b1;
    send_frame(2, 0, NPIX - 1, 1'b1, 1'b1, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    stall_mode = 1'b0;
    drain();
    check("t2_len", 32'(cap_data.size()), 32'd32);
    check_crop("t2", 0, 2, 10, 5, 8, 4);
    check("t2_stable", 32'(stab_viol), 32'd0);
    check("t2_ready_only_full", 32'(skid_viol), 32'd0);
    check("t2_backpressure_seen", 32'(inrdy_low != 0), 32'd1);
    check("t2_done", 32'(done_cnt), 32'd1);
    check("t2_err", 32'(err_cnt), 32'd0);

    // Illegal ROI (30,0,4,1): 30+4 > 32, whole frame passes.
    set_roi(30, 0, 4, 1);
    clear_obs();
    send_frame(3, 0, NPIX - 1, 1'b1, 1'b1, 1'b0);
    drain();
    check("t3_roi_inv", 32'(roi_invalid), 32'd1);
    check("t3_len", 32'(cap_data.size()), 32'(NPIX));
    check_crop("t3", 0, 3, 0, 0, W, H);
    check("t3_done", 32'(done_cnt), 32'd1);
    check("t3_err", 32'(err_cnt), 32'd0);

    // ROI (0,0,1,1): single beat with SOP and EOP, roi_invalid clears.
    set_roi(0, 0, 1, 1);
    clear_obs();
    send_frame(4, 0, NPIX - 1, 1'b1, 1'b1, 1'b0);
    drain();
    check("t4_len", 32'(cap_data.size()), 32'd1);
    check_beat("t4", 0, 4, 0, 2'b11);
    check("t4_roi_inv", 32'(roi_invalid), 32'd0);

    // Truncated at index 200 (y=6,x=8, outside ROI): 8 row-5 beats then EOP beat 200.
    set_roi(10, 5, 8, 4);
    clear_obs();
    send_frame(5, 0, 200, 1'b1, 1'b1, 1'b0);
    drain();
    check("t5_len", 32'(cap_data.size()), 32'd9);
    for (int k = 0; k < 8; k++) check_beat("t5", k, 5, 170 + k, {k == 0, 1'b0});
    check_beat("t5_eop", 8, 5, 200, 2'b01);
    check("t5_done", 32'(done_cnt), 32'd1);
    check("t5_err", 32'(err_cnt), 32'd1);
    check("t5_same_cycle", 32'(both_cnt), 32'd1);

    // New SOP at index 200 with packet open: filler beat, error, then clean new frame.
    clear_obs();
    send_frame(6, 0, 199, 1'b1, 1'b0, 1'b0);
    send_frame(7, 0, NPIX - 1, 1'b1, 1'b1, 1'b0);
    drain();
    check("t6_len", 32'(cap_data.size()), 32'd41);
    for (int k = 0; k < 8; k++) check_beat("t6", k, 6, 170 + k, {k == 0, 1'b0});
    check_beat("t6_filler", 8, 0, 0, 2'b01);
    check_crop("t6_new", 9, 7, 10, 5, 8, 4);
    check("t6_in_ready_low", 32'(inrdy_low), 32'd1);
    check("t6_err", 32'(err_cnt), 32'd1);
    check("t6_done", 32'(done_cnt), 32'd1);

    // Asynchronous reset mid-frame, then headless beats are dropped until SOP.
    clear_obs();
    send_frame(8, 0, 180, 1'b1, 1'b0, 1'b0);
    check("t7_pre_len", 32'(cap_data.size()), 32'd8);
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_rst_out", 32'({out_if.valid, out_if.startofpacket, out_if.endofpacket, out_if.data}), 32'd0);
    check("t7_rst_status", 32'({frame_done, frame_error, in_if.ready}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_obs();
    send_frame(8, 181, 400, 1'b0, 1'b0, 1'b0);
    drain();
    check("t7_dropped", 32'(cap_data.size()), 32'd0);
    check("t7_no_status", 32'(done_cnt + err_cnt), 32'd0);
    send_frame(9, 0, NPIX - 1, 1'b1, 1'b1, 1'b0);
    drain();
    check("t7_len", 32'(cap_data.size()), 32'd32);
    check_crop("t7", 0, 9, 10, 5, 8, 4);
    check("t7_done", 32'(done_cnt), 32'd1);
    check("t7_err", 32'(err_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/video_roi_cropper.md
Name: video_roi_cropper

Overview:
- Streaming stage directly downstream of the video-in scaler source: consumes 24-bit RGB Avalon-ST video frames, tracks pixel x/y, and forwards only pixels inside a runtime-selectable rectangular region of interest (ROI).
- Output is a well-formed Avalon-ST packet (one per frame) sized ROI_W x ROI_H, driven into the feed-forward sink of the video-in subsystem.
- Provides per-frame status pulses for firmware and bench checking.

Parameters:
- IN_WIDTH, 320, input frame width in pixels
- IN_HEIGHT, 240, input frame height in lines
- DATA_W, 24, pixel width (RGB888)
- CW, 9, coordinate width; must satisfy 2^CW > max(IN_WIDTH, IN_HEIGHT)

Ports:
- clk_clk  in  1  sole clock
- reset_reset_n  in  1  asynchronous active-low reset
- roi_x  in  CW  ROI left column; sampled on accepted input SOP
- roi_y  in  CW  ROI top line; sampled on accepted input SOP
- roi_w  in  CW  ROI width; sampled on accepted input SOP
- roi_h  in  CW  ROI height; sampled on accepted input SOP
- in_data  in  DATA_W  pixel
- in_startofpacket  in  1  first pixel of frame
- in_endofpacket  in  1  last pixel of frame
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid & in_ready
- out_data  out  DATA_W  pixel
- out_startofpacket  out  1  first ROI pixel
- out_endofpacket  out  1  last ROI pixel
- out_empty  out  2  tied 0
- out_valid  out  1  beat valid
- out_ready  in  1  downstream ready
- frame_done  out  1  1-cycle pulse on accepted input EOP
- frame_error  out  1  1-cycle pulse on malformed frame
- roi_invalid  out  1  level; ROI latched for current frame was illegal

Behaviour:
- Clock/reset: one clock domain; reset is asynchronous, active-low.
- Reset values: all outputs 0, except in_ready = 1 once reset deasserts; state IDLE; counters 0; skid buffer empty.
- Datapath: 2-entry skid buffer (main + skid register). Latency is 1 cycle, input accept to out_valid. Full throughput of 1 pixel/clk when out_ready = 1.
- in_ready is registered and equals !skid_full. It is never combinationally dependent on out_ready.
- out_* must stay stable while out_valid & !out_ready.
- States:
  - IDLE: beats without SOP are discarded, with in_ready = 1. An accepted SOP latches the ROI, sets x = y = 0, processes the beat as pixel (0,0), and moves to ACTIVE.
  - ACTIVE: each accepted beat is tested, then x++. At x == IN_WIDTH-1, x wraps to 0 and y++. y saturates at 2^CW-1.
  - CLOSE: entered when an SOP arrives in ACTIVE while the output packet is open (SOP emitted, EOP not).
    - in_ready = 0 for one accept slot.
    - Emit one filler beat: data 0, eop = 1.
    - Pulse frame_error.
    - Then treat the held SOP beat as a fresh frame start and return to ACTIVE.
    - If no output packet is open, restart directly without CLOSE; frame_error still pulses.
- Keep test: roi_x <= x < roi_x+roi_w and roi_y <= y < roi_y+roi_h. Use CW+1 bit sums; no wrap.
- Output flags: out_sop = keep & x == roi_x & y == roi_y. out_eop = keep & x == roi_x+roi_w-1 & y == roi_y+roi_h-1.
- Illegal ROI: roi_w == 0, roi_h == 0, roi_x+roi_w > IN_WIDTH, or roi_y+roi_h > IN_HEIGHT.
  - The ROI is replaced by the full frame (0, 0, IN_WIDTH, IN_HEIGHT).
  - roi_invalid is set for that frame and cleared at the next legal SOP.
- Accepted in_eop:
  - frame_done pulses and the state returns to IDLE.
  - If total accepted beats != IN_WIDTH*IN_HEIGHT, frame_error pulses (same cycle as frame_done).
  - Early EOP with an open output packet: that beat is emitted with out_eop = 1 even when outside the ROI.
  - Beats after the ROI end and beats beyond IN_WIDTH*IN_HEIGHT are dropped. Late EOP is therefore only an error pulse.
- SOP and EOP on the same beat: 1-pixel frame. Process pixel (0,0), then apply the EOP rules; return to IDLE.
- ROI inputs are ignored except at accepted SOP, so mid-frame changes have no effect.

Test Plan:
- 320x240 frame, ROI (100,50,64,32), out_ready = 1 → exactly 2048 output beats. SOP on the pixel with in-frame index 50*320+100 = 16100, EOP on index 81*320+163 = 26083; frame_done pulses once; no frame_error.
- Same frame with out_ready toggling in a 1-on/2-off pattern → identical 2048-beat sequence. No beat lost or duplicated, out_* stable while stalled, in_ready drops only when the skid is full.
- ROI (300,0,40,10) → roi_invalid = 1 and the full 76800-pixel frame passes unchanged. The next frame with ROI (0,0,1,1) gives a single beat with SOP = EOP = 1 and roi_invalid clears.
- Frame truncated by EOP at pixel index 20000 with ROI (100,50,64,32) → the EOP beat is emitted with out_eop = 1; frame_error and frame_done pulse in the same cycle.
- SOP arriving at pixel index 20000 (no EOP) → in_ready low one cycle, filler beat (data 0, eop = 1), frame_error pulse, then the new frame is cropped correctly.
- reset_reset_n asserted mid-frame → outputs 0 asynchronously. Beats after release are discarded until the next SOP, then normal cropping resumes.
